// File: rtl/uart_tx_engine_if.sv
// Byte write port into the UART transmit FIFO.
// The master drives each byte with a one-cycle strobe and watches the full flag.
interface uart_tx_engine_if;
    logic       fifowrreq;
    logic [7:0] fifowdata;
    logic       fifowrfull;

    modport master (
        output fifowrreq,
        output fifowdata,
        input  fifowrfull
    );

    modport slave (
        input  fifowrreq,
        input  fifowdata,
        output fifowrfull
    );
endinterface

// File: rtl/uart_tx_engine.sv
// UART transmitter: byte FIFO feeding a start/data/parity/stop framer.
// Baud timing, frame format and data are latched per frame.
module uart_tx_engine #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    uart_tx_engine_if.slave wr_if,
    input  logic [11:0]     tx_cnt,
    input  logic [1:0]      parity,
    output logic            txd,
    output logic            tx_busy,
    output logic            tx_done
);
    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          r_full;

    logic [2:0]    r_state;
    logic [7:0]    r_data;
    logic [2:0]    r_idx;
    logic [11:0]   r_cnt_lat;
    logic [1:0]    r_par_lat;
    logic [11:0]   r_baud;
    logic          r_half;
    logic          r_txd;

    logic          w_push;
    logic          w_pop;
    logic          w_empty;
    logic          w_bit_end;
    logic          w_stop_end;
    logic          w_par_bit;
    logic [AW:0]   w_count_nxt;

    // A full FIFO drops the write even when a pop frees a slot this cycle.
    assign w_push     = wr_if.fifowrreq & ~r_full;
    assign w_empty    = (r_count == '0);
    assign w_bit_end  = (r_baud == 12'd0) & r_half;
    assign w_stop_end = (r_state == S_STOP) & w_bit_end;
    assign w_pop      = ~w_empty & ((r_state == S_IDLE) | w_stop_end);
    assign w_par_bit  = r_par_lat[0] ? ~^r_data : ^r_data;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + (AW+1)'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= wr_if.fifowdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == DEPTH_C);
        end
    end

    // Each bit is two half periods of (r_cnt_lat + 1) clocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_data    <= 8'd0;
            r_idx     <= 3'd0;
            r_cnt_lat <= 12'd0;
            r_par_lat <= 2'd0;
            r_baud    <= 12'd0;
            r_half    <= 1'b0;
            r_txd     <= 1'b1;
        end else if (w_pop) begin
            r_state   <= S_START;
            r_data    <= r_mem[r_rptr];
            r_idx     <= 3'd0;
            r_cnt_lat <= tx_cnt;
            r_par_lat <= parity;
            r_baud    <= tx_cnt;
            r_half    <= 1'b0;
            r_txd     <= 1'b0;
        end else if (r_state != S_IDLE) begin
            if (r_baud != 12'd0) begin
                r_baud <= r_baud - 12'd1;
            end else if (!r_half) begin
                r_half <= 1'b1;
                r_baud <= r_cnt_lat;
            end else begin
                r_half <= 1'b0;
                r_baud <= r_cnt_lat;
                case (r_state)
                    S_START: begin
                        r_state <= S_DATA;
                        r_idx   <= 3'd0;
                        r_txd   <= r_data[0];
                    end
                    S_DATA: begin
                        if (r_idx == 3'd7) begin
                            if (r_par_lat[1]) begin
                                r_state <= S_PARITY;
                                r_txd   <= w_par_bit;
                            end else begin
                                r_state <= S_STOP;
                                r_txd   <= 1'b1;
                            end
                        end else begin
                            r_idx <= r_idx + 3'd1;
                            r_txd <= r_data[r_idx + 3'd1];
                        end
                    end
                    S_PARITY: begin
                        r_state <= S_STOP;
                        r_txd   <= 1'b1;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_txd   <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign txd              = r_txd;
    assign tx_busy          = (r_state != S_IDLE);
    assign tx_done          = w_stop_end;
    assign wr_if.fifowrfull = r_full;
endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: frame-level line model compared every cycle,
// plus directed frames with hand-computed bit patterns.
module tb_uart_tx_engine;
    localparam int DEPTH = 16;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] tx_cnt;
    logic [1:0]  parity;
    logic        txd;
    logic        tx_busy;
    logic        tx_done;

    uart_tx_engine_if wif();

    uart_tx_engine #(.FIFO_DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_if   (wif.slave),
        .tx_cnt  (tx_cnt),
        .parity  (parity),
        .txd     (txd),
        .tx_busy (tx_busy),
        .tx_done (tx_done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void chk(string nm, logic [31:0] a, logic [31:0] e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            if (n_fail < 30)
                $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endfunction

    // Line model: queue of accepted bytes and the frame currently on the wire.
    logic [7:0]  m_q[$];
    logic        m_act = 1'b0;
    logic [10:0] m_fb  = '1;
    int          m_fn  = 10;
    int          m_pos = 0;
    int          m_rem = 0;
    int          m_bl  = 2;

    function automatic void m_load();
        logic [7:0] d;
        d      = m_q.pop_front();
        m_bl   = 2 * (int'(tx_cnt) + 1);
        m_fn   = parity[1] ? 11 : 10;
        m_fb   = '1;
        m_fb[0] = 1'b0;
        m_fb[8:1] = d;
        if (parity[1])
            m_fb[9] = parity[0] ? ~^d : ^d;
        m_pos  = 0;
        m_rem  = m_bl;
        m_act  = 1'b1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_act = 1'b0;
        end else begin
            bit full0;
            full0 = (m_q.size() == DEPTH);
            if (m_act) begin
                if (m_rem > 1) begin
                    m_rem--;
                end else begin
                    m_pos++;
                    m_rem = m_bl;
                    if (m_pos == m_fn) m_act = 1'b0;
                end
            end
            if (!m_act && m_q.size() > 0) m_load();
            if (wif.fifowrreq && !full0) m_q.push_back(wif.fifowdata);
        end
    end

    int cyc      = 0;
    int n_done   = 0;
    int last_done = 0;
    int done_gap = 0;

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            chk("model_txd", txd, m_act ? m_fb[m_pos] : 1'b1);
            chk("model_busy", tx_busy, m_act);
            chk("model_done", tx_done,
                m_act && (m_pos == m_fn - 1) && (m_rem == 1));
            chk("model_full", wif.fifowrfull, m_q.size() == DEPTH);
            if (tx_done) begin
                n_done++;
                done_gap  = cyc - last_done;
                last_done = cyc;
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [7:0] d);
        wif.fifowrreq = 1'b1;
        wif.fifowdata = d;
        @(posedge clk);
        #2;
        wif.fifowrreq = 1'b0;
    endtask

    task automatic wait_idle();
        int w = 0;
        while (tx_busy !== 1'b0 && w < 50000) begin
            @(negedge clk);
            w++;
        end
        chk("wait_idle_timeout", tx_busy, 1'b0);
    endtask

    task automatic check_frame(input string nm, input int nb,
                               input logic [10:0] bits, input int cpb,
                               output int lat);
        int bad = 0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (txd !== 1'b0 && lat < 5000);
        chk({nm, "_start_seen"}, txd, 1'b0);
        for (int i = 0; i < nb; i++) begin
            for (int c = 0; c < cpb; c++) begin
                if (i != 0 || c != 0) @(negedge clk);
                if (txd !== bits[i]) bad++;
            end
        end
        chk({nm, "_bad_clocks"}, bad, 0);
    endtask

    task automatic rx_byte(input int p, output logic [7:0] b);
        int w = 0;
        b = 8'd0;
        do begin
            @(negedge clk);
            w++;
        end while (txd !== 1'b0 && w < 5000);
        repeat (p / 2) @(negedge clk);
        chk("rx_start_mid", txd, 1'b0);
        for (int i = 0; i < 8; i++) begin
            repeat (p) @(negedge clk);
            b[i] = txd;
        end
        repeat (p) @(negedge clk);
        chk("rx_stop_mid", txd, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        int lat;
        int lat1;
        int d0;
        logic [7:0] b;

        wif.fifowrreq = 1'b0;
        wif.fifowdata = 8'd0;
        tx_cnt = 12'd1;
        parity = 2'b00;

        repeat (3) @(negedge clk);
        chk("rst_txd", txd, 1'b1);
        chk("rst_busy", tx_busy, 1'b0);
        chk("rst_done", tx_done, 1'b0);
        chk("rst_full", wif.fifowrfull, 1'b0);
        sync();
        rst_n = 1'b1;
        sync();

        // 0x55, 4 clocks per bit, no parity
        d0 = n_done;
        wr(8'h55);
        check_frame("t1", 10, 11'h2AA, 4, lat);
        chk("t1_latency", lat, 2);
        chk("t1_done_last_stop", tx_done, 1'b1);
        chk("t1_busy_last_stop", tx_busy, 1'b1);
        @(negedge clk);
        chk("t1_busy_after", tx_busy, 1'b0);
        chk("t1_done_after", tx_done, 1'b0);
        chk("t1_done_count", n_done - d0, 1);

        // odd and even parity, 2 clocks per bit
        wait_idle();
        sync();
        tx_cnt = 12'd0;
        parity = 2'b11;
        wr(8'h03);
        check_frame("t2_odd", 11, 11'b110_0000_0110, 2, lat);
        wait_idle();
        sync();
        parity = 2'b10;
        wr(8'h07);
        check_frame("t2_even", 11, 11'b110_0000_1110, 2, lat);

        // two queued bytes run back to back
        wait_idle();
        sync();
        tx_cnt = 12'd1;
        parity = 2'b00;
        d0 = n_done;
        wr(8'h55);
        wr(8'h5A);
        check_frame("t3_f1", 10, 11'h2AA, 4, lat);
        check_frame("t3_f2", 10, 11'h2B4, 4, lat);
        chk("t3_no_gap", lat, 1);
        @(negedge clk);
        chk("t3_done_count", n_done - d0, 2);
        chk("t3_done_gap", done_gap, 40);

        // settings changed mid-frame apply to the next frame only
        wait_idle();
        sync();
        wr(8'h5A);
        wr(8'h3C);
        fork
            check_frame("t4_f1", 10, 11'h2B4, 4, lat1);
            begin
                repeat (8) @(posedge clk);
                #2;
                tx_cnt = 12'd5;
                parity = 2'b11;
            end
        join
        check_frame("t4_f2", 11, 11'h678, 12, lat);
        chk("t4_no_gap", lat, 1);

        // overflow: 17 accepted, 18th dropped
        wait_idle();
        sync();
        tx_cnt = 12'd100;
        parity = 2'b00;
        d0 = n_done;
        fork
            begin
                for (int i = 0; i < 17; i++) begin
                    if (i == 16) chk("t5_full_before_17", wif.fifowrfull, 1'b0);
                    wr(8'(i));
                end
                chk("t5_full_after_17", wif.fifowrfull, 1'b1);
                wr(8'hAA);
                chk("t5_full_after_18", wif.fifowrfull, 1'b1);
            end
            begin
                for (int k = 0; k < 17; k++) begin
                    rx_byte(202, b);
                    chk("t5_order", b, 8'(k));
                end
            end
        join
        wait_idle();
        chk("t5_done_count", n_done - d0, 17);
        chk("t5_full_end", wif.fifowrfull, 1'b0);

        // reset in the middle of data bit 3
        sync();
        tx_cnt = 12'd1;
        wr(8'h0F);
        wr(8'hA1);
        wr(8'hB2);
        lat = 0;
        while (txd !== 1'b0 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        repeat (17) @(negedge clk);
        chk("t6_busy_pre", tx_busy, 1'b1);
        sync();
        rst_n = 1'b0;
        #1;
        chk("t6_txd_async", txd, 1'b1);
        chk("t6_busy_async", tx_busy, 1'b0);
        chk("t6_done_async", tx_done, 1'b0);
        chk("t6_full_async", wif.fifowrfull, 1'b0);
        wif.fifowrreq = 1'b1;
        wif.fifowdata = 8'hEE;
        sync();
        sync();
        wif.fifowrreq = 1'b0;
        sync();
        rst_n = 1'b1;
        d0 = n_done;
        repeat (200) @(negedge clk);
        chk("t6_txd_after", txd, 1'b1);
        chk("t6_busy_after", tx_busy, 1'b0);
        chk("t6_full_after", wif.fifowrfull, 1'b0);
        chk("t6_no_done", n_done - d0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
